// File: rtl/mdu_ctrl.sv
// Multiply/divide unit for the E stage: owns HI/LO, models fixed mult/div latency
// with a busy counter, and raises the D-stage stall while the unit is occupied.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  mdu_op,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   input  logic        d_md_use,
   output logic        busy,
   output logic        stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mf_data
);
   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic [1:0] {IDLE, MULT, DIV} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d;
   logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
   logic          pend_wr_q, pend_wr_d;

   logic          idle, start_md;
   logic [63:0]   prod_s, prod_u;
   logic          a_neg, b_neg;
   logic [31:0]   a_abs, b_abs, uq, ur, quo, rem;

   assign idle     = (state_q == IDLE);
   assign start_md = idle && (mdu_op >= 4'd1) && (mdu_op <= 4'd4);
   assign busy     = !idle;
   assign stall    = d_md_use && (busy || start_md);
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign mf_data  = (mdu_op == 4'd5) ? hi_q : (mdu_op == 4'd6) ? lo_q : 32'h0;

   // Low 64 bits of the sign-extended product equal the signed 64-bit product.
   assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
   assign prod_u = {32'h0, rs_data} * {32'h0, rt_data};

   // Sign-magnitude division: well defined for 0x80000000 / -1 as well.
   assign a_neg = (mdu_op == 4'd3) && rs_data[31];
   assign b_neg = (mdu_op == 4'd3) && rt_data[31];
   assign a_abs = a_neg ? -rs_data : rs_data;
   assign b_abs = b_neg ? -rt_data : rt_data;
   assign uq    = (b_abs == 32'h0) ? 32'h0 : a_abs / b_abs;
   assign ur    = (b_abs == 32'h0) ? 32'h0 : a_abs % b_abs;
   assign quo   = (a_neg ^ b_neg) ? -uq : uq;
   assign rem   = a_neg ? -ur : ur;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      case (state_q)
         IDLE: begin
            case (mdu_op)
               4'd1, 4'd2: begin
                  {pend_hi_d, pend_lo_d} = (mdu_op == 4'd1) ? prod_s : prod_u;
                  pend_wr_d = 1'b1;
                  cnt_d     = CW'(MULT_CYCLES);
                  state_d   = MULT;
               end
               4'd3, 4'd4: begin
                  pend_hi_d = rem;
                  pend_lo_d = quo;
                  pend_wr_d = (rt_data != 32'h0);  // divide by zero leaves HI/LO alone
                  cnt_d     = CW'(DIV_CYCLES);
                  state_d   = DIV;
               end
               4'd7:    hi_d = rs_data;
               4'd8:    lo_d = rs_data;
               default: ;
            endcase
         end
         MULT, DIV: begin
            if (cnt_q == CW'(1)) begin
               if (pend_wr_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
               cnt_d   = '0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         hi_q      <= 32'h0;
         lo_q      <= 32'h0;
         pend_hi_q <= 32'h0;
         pend_lo_q <= 32'h0;
         pend_wr_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end
endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected {hi,lo} pushed at issue, popped when busy drops.
module tb_mdu_ctrl;
   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  mdu_op;
   logic [31:0] rs_data, rt_data;
   logic        d_md_use;
   logic        busy, stall;
   logic [31:0] hi, lo, mf_data;

   int passed = 0;
   int total  = 0;
   logic [63:0] exp_q[$];

   always #5 clk = ~clk;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .mdu_op(mdu_op), .rs_data(rs_data), .rt_data(rt_data),
      .d_md_use(d_md_use), .busy(busy), .stall(stall), .hi(hi), .lo(lo), .mf_data(mf_data)
   );

   task automatic start_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp_hl);
      mdu_op = op; rs_data = a; rt_data = b;
      #1;
      total++;
      if (stall !== d_md_use) $display("FAIL start_stall op=%0d got=%b exp=%b", op, stall, d_md_use);
      else passed++;
      exp_q.push_back(exp_hl);
      @(posedge clk); #1;
      mdu_op = 4'd0;
   endtask

   // Counts busy cycles, optionally injects an mtlo while busy, then checks the result.
   task automatic wait_done(input int n, input string nm, input logic intrude);
      int cyc = 0;
      logic [63:0] e;
      while (busy === 1'b1 && cyc < 100) begin
         if (intrude && cyc == 1) begin mdu_op = 4'd8; rs_data = 32'hDEAD_0000; end
         #1;
         total++;
         if (stall !== d_md_use) $display("FAIL %s_busy_stall cyc=%0d got=%b exp=%b", nm, cyc, stall, d_md_use);
         else passed++;
         cyc++;
         @(posedge clk); #1;
         mdu_op = 4'd0;
      end
      total++;
      if (cyc != n) $display("FAIL %s_busy_len got=%0d exp=%0d", nm, cyc, n);
      else passed++;
      total++;
      if (exp_q.size() == 0) begin
         $display("FAIL %s_scoreboard_empty got=0 exp=1", nm);
      end else begin
         passed++;
         e = exp_q.pop_front();
         total++;
         if (hi !== e[63:32]) $display("FAIL %s_hi got=%h exp=%h", nm, hi, e[63:32]);
         else passed++;
         total++;
         if (lo !== e[31:0]) $display("FAIL %s_lo got=%h exp=%h", nm, lo, e[31:0]);
         else passed++;
      end
      total++;
      if (stall !== 1'b0) $display("FAIL %s_stall_after got=%b exp=0", nm, stall);
      else passed++;
   endtask

   task automatic test_reset();
      reset = 1'b0; mdu_op = 4'd0; rs_data = 32'h0; rt_data = 32'h0; d_md_use = 1'b0;
      repeat (2) @(posedge clk);
      #4 reset = 1'b1;
      @(posedge clk); #1;
      total++;
      if (busy !== 1'b0 || stall !== 1'b0) $display("FAIL reset_busy got=%b%b exp=00", busy, stall);
      else passed++;
      total++;
      if (hi !== 32'h0 || lo !== 32'h0 || mf_data !== 32'h0)
         $display("FAIL reset_hilo got=%h/%h/%h exp=0/0/0", hi, lo, mf_data);
      else passed++;
   endtask

   task automatic test_mult();
      start_op(4'd1, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
      wait_done(5, "mult", 1'b0);
   endtask

   task automatic test_back_to_back();
      start_op(4'd2, 32'hFFFF_FFFF, 32'd2, {32'h0000_0001, 32'hFFFF_FFFE});
      wait_done(5, "multu", 1'b0);
      mdu_op = 4'd5; #1;
      total++;
      if (mf_data !== 32'h1) $display("FAIL mfhi_fresh got=%h exp=00000001", mf_data);
      else passed++;
      start_op(4'd3, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      wait_done(10, "div_neg", 1'b0);
   endtask

   task automatic test_div_edge();
      start_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000});
      wait_done(10, "div_ovf", 1'b0);
      mdu_op = 4'd7; rs_data = 32'h1234;
      @(posedge clk); #1;
      mdu_op = 4'd0;
      total++;
      if (hi !== 32'h1234 || busy !== 1'b0) $display("FAIL mthi got=%h/%b exp=00001234/0", hi, busy);
      else passed++;
      start_op(4'd4, 32'd100, 32'd0, {32'h1234, 32'h8000_0000});
      wait_done(10, "divu_zero", 1'b0);
   endtask

   task automatic test_stall();
      d_md_use = 1'b1;
      start_op(4'd1, 32'd4, 32'd5, {32'h0, 32'd20});
      wait_done(5, "stall_mult", 1'b1);  // mtlo injected while busy must be ignored
      d_md_use = 1'b0;
      start_op(4'd2, 32'd3, 32'd3, {32'h0, 32'd9});
      wait_done(5, "nostall_mult", 1'b0);
   endtask

   task automatic test_mt_mf();
      mdu_op = 4'd8; rs_data = 32'hCAFE_BABE;
      @(posedge clk); #1;
      mdu_op = 4'd0;
      total++;
      if (lo !== 32'hCAFE_BABE || busy !== 1'b0) $display("FAIL mtlo got=%h/%b exp=cafebabe/0", lo, busy);
      else passed++;
      @(posedge clk); #1;
      mdu_op = 4'd6; #1;
      total++;
      if (mf_data !== 32'hCAFE_BABE) $display("FAIL mflo got=%h exp=cafebabe", mf_data);
      else passed++;
      mdu_op = 4'd12; #1;
      total++;
      if (mf_data !== 32'h0) $display("FAIL mf_other got=%h exp=0", mf_data);
      else passed++;
      mdu_op = 4'd0;
      @(posedge clk); #1;
   endtask

   task automatic test_async_reset();
      start_op(4'd3, 32'd7, 32'd3, {32'd1, 32'd2});
      repeat (2) begin @(posedge clk); #1; end
      #2 reset = 1'b0;
      #1;
      total++;
      if (busy !== 1'b0 || hi !== 32'h0 || lo !== 32'h0)
         $display("FAIL async_reset got=%b/%h/%h exp=0/0/0", busy, hi, lo);
      else passed++;
      void'(exp_q.pop_back());
      #1 reset = 1'b1;
      @(posedge clk); #1;
      start_op(4'd1, 32'd6, 32'd7, {32'h0, 32'd42});
      wait_done(5, "mult_after_rst", 1'b0);
   endtask

   initial begin
      test_reset();
      test_mult();
      test_back_to_back();
      test_div_edge();
      test_stall();
      test_mt_mf();
      test_async_reset();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
